// File: rtl/nano_mem_pkg.sv
// Shared types and address helpers for the line-miss memory responder.
package nano_mem_pkg;

   typedef logic [7:0][31:0] line_t;
   typedef logic [7:0][3:0]  strb_t;

   localparam int unsigned LINE_OFF_W = 5;

   // Line index of a byte address; offset bits and bits above the array depth drop out.
   function automatic logic [31:0] line_idx(input logic [31:0] addr, input int unsigned line_aw);
      return (addr >> LINE_OFF_W) & ((32'd1 << line_aw) - 32'd1);
   endfunction

endpackage

// File: rtl/nano_line_sram.sv
// Line-wide SRAM built from 8 word banks: byte-enabled shared write port,
// registered full-line read that only updates when a read is issued.
module nano_line_sram
   import nano_mem_pkg::*;
#(
   parameter int unsigned LINE_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_AW-1:0] waddr,
   input  line_t              wdata,
   input  strb_t              wbe,
   input  logic               re,
   input  logic [LINE_AW-1:0] raddr,
   output line_t              rdata
);

   for (genvar w = 0; w < 8; w++) begin : g_bank
      logic [31:0] mem [2**LINE_AW];
      logic [31:0] rd_q;

      always_ff @(posedge clk) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wbe[w][b]) mem[waddr][b*8 +: 8] <= wdata[w][b*8 +: 8];
         end
      end

      // Read-before-write: a read sharing the edge with a write sees old contents.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)     rd_q <= '0;
         else if (re) rd_q <= mem[raddr];
      end

      assign rdata[w] = rd_q;
   end

endmodule

// File: rtl/nano_line_mem_resp.sv
// Memory-side responder for the cache line-miss port: grant logic, preload
// priority muxing into the line SRAM, and a fixed-latency read pipeline.
module nano_line_mem_resp
   import nano_mem_pkg::*;
#(
   parameter int unsigned LINE_AW = 10,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mm_rden,
   input  logic        i_mm_wren,
   input  logic [31:0] i_mm_addr,
   input  line_t       i_mm_wdata,
   input  strb_t       i_mm_wstrb,
   output logic        o_mm_gnt,
   output line_t       o_mm_rdata,
   output logic        o_mm_rvalid,
   output logic        o_mm_err,
   input  logic        i_ld_wren,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_wdata
);

   logic               gnt;
   logic               rd_go;
   logic [LINE_AW-1:0] cache_idx;
   logic [LINE_AW-1:0] ld_idx;
   logic [LINE_AW-1:0] waddr;
   line_t              wdata;
   strb_t              wbe;
   line_t              sram_rdata;
   logic [RD_LAT-1:0]  vld;

   assign cache_idx = LINE_AW'(line_idx(i_mm_addr, LINE_AW));
   assign ld_idx    = LINE_AW'(line_idx(i_ld_addr, LINE_AW));

   assign gnt      = (i_mm_rden | i_mm_wren) & ~i_ld_wren & ~i_rst;
   // A read colliding with a write is dropped; only the write proceeds.
   assign rd_go    = gnt & i_mm_rden & ~i_mm_wren;
   assign o_mm_gnt = gnt;
   assign o_mm_err = gnt & i_mm_rden & i_mm_wren;

   always_comb begin
      waddr = cache_idx;
      wdata = i_mm_wdata;
      wbe   = '0;
      if (i_ld_wren) begin
         waddr = ld_idx;
         for (int unsigned w = 0; w < 8; w++) wdata[w] = i_ld_wdata;
         wbe[i_ld_addr[4:2]] = 4'hF;
      end else if (gnt && i_mm_wren) begin
         wbe = i_mm_wstrb;
      end
   end

   nano_line_sram #(
      .LINE_AW (LINE_AW)
   ) u_sram (
      .clk   (i_clk),
      .rst   (i_rst),
      .waddr (waddr),
      .wdata (wdata),
      .wbe   (wbe),
      .re    (rd_go),
      .raddr (cache_idx),
      .rdata (sram_rdata)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld <= '0;
      end else begin
         vld[0] <= rd_go;
         for (int unsigned k = 1; k < RD_LAT; k++) vld[k] <= vld[k-1];
      end
   end

   assign o_mm_rvalid = vld[RD_LAT-1];

   // The SRAM output register is the first pipeline stage; later stages load only when valid.
   if (RD_LAT == 1) begin : g_direct
      assign o_mm_rdata = sram_rdata;
   end else begin : g_pipe
      line_t pipe [RD_LAT-1];

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            for (int unsigned k = 0; k < RD_LAT-1; k++) pipe[k] <= '0;
         end else begin
            if (vld[0]) pipe[0] <= sram_rdata;
            for (int unsigned k = 1; k < RD_LAT-1; k++) begin
               if (vld[k]) pipe[k] <= pipe[k-1];
            end
         end
      end

      assign o_mm_rdata = pipe[RD_LAT-2];
   end

endmodule
